topdown_counter_ctrl: RTL and testbench

// Controls the per-component top-down event counters. Takes one-cycle increment pulses from

---
 rtl/topdown_counter_ctrl_if.sv | 23 ++
 rtl/topdown_counter_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_topdown_counter_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/topdown_counter_ctrl_if.sv
// Configuration/register port of the top-down counter controller.
// The CPU-side register master drives strobe, address and write data;
// the controller answers with combinational read data.
interface topdown_counter_ctrl_if;
    logic        cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;

    modport master (
        output cfg_we_i,
        output cfg_addr_i,
        output cfg_wdata_i,
        input  cfg_rdata_o
    );

    modport slave (
        input  cfg_we_i,
        input  cfg_addr_i,
        input  cfg_wdata_i,
        output cfg_rdata_o
    );
endinterface

// File: rtl/topdown_counter_ctrl.sv
// Top-down event counter controller.
// Accumulates per-component increment pulses from topdown_monitor into live
// counters over a programmable sampling window, and exposes shadow snapshots,
// sticky overflow flags and control through a small register port.
// Optional feature: define TOPDOWN_CNT_SATURATE_EN to make the live counters
// saturate at all-ones instead of wrapping.
// Register map: 0 CTRL (START/STOP/CLEAR/SNAP), 1 WINDOW, 2 INHIBIT,
// 3 STATUS, 8+i CNT_i. WIN_W must not exceed 32; N_COMPS must not exceed 8.
module topdown_counter_ctrl #(
    parameter int N_COMPS = 6,
    parameter int CNT_W   = 32,
    parameter int WIN_W   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    topdown_counter_ctrl_if.slave   cfg,
    input  logic [N_COMPS-1:0]      comp_incr_i,
    output logic                    busy_o,
    output logic                    window_done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1
    } state_t;

    localparam logic [3:0]       ADDR_CTRL    = 4'd0;
    localparam logic [3:0]       ADDR_WINDOW  = 4'd1;
    localparam logic [3:0]       ADDR_INHIBIT = 4'd2;
    localparam logic [3:0]       ADDR_STATUS  = 4'd3;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE      = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_ZERO     = '0;

    state_t                          state_q, state_d;
    logic [WIN_W-1:0]                remaining_q, remaining_d;
    logic [WIN_W-1:0]                window_q, window_d;
    logic [N_COMPS-1:0]              inhibit_q, inhibit_d;
    logic [N_COMPS-1:0]              ovf_q, ovf_d;
    logic [N_COMPS-1:0][CNT_W-1:0]   live_q, live_d;
    logic [N_COMPS-1:0][CNT_W-1:0]   shadow_q, shadow_d;
    logic                            done_q, done_d;

    logic                            ctrl_wr;
    logic                            start_cmd;
    logic                            stop_cmd;
    logic                            clear_cmd;
    logic                            snap_cmd;
    logic                            counting;
    logic [N_COMPS-1:0]              eff_incr;
    logic [N_COMPS-1:0][CNT_W-1:0]   inc_val;
    logic [N_COMPS-1:0]              inc_ovf;

    // Decode CTRL command bits; STOP overrides a simultaneous START.
    always_comb begin
        ctrl_wr   = cfg.cfg_we_i && (cfg.cfg_addr_i == ADDR_CTRL);
        stop_cmd  = ctrl_wr && cfg.cfg_wdata_i[1];
        start_cmd = ctrl_wr && cfg.cfg_wdata_i[0] && !cfg.cfg_wdata_i[1];
        clear_cmd = ctrl_wr && cfg.cfg_wdata_i[2];
        snap_cmd  = ctrl_wr && cfg.cfg_wdata_i[3];
        counting  = (state_q == S_COUNT);
        eff_incr  = counting ? (comp_incr_i & ~inhibit_q) : '0;
    end

    // Per-component "live + this cycle's increment" value and overflow event.
    always_comb begin
        for (int i = 0; i < N_COMPS; i++) begin
            inc_val[i] = live_q[i];
            inc_ovf[i] = 1'b0;
            if (eff_incr[i]) begin
`ifdef TOPDOWN_CNT_SATURATE_EN
                if (live_q[i] == CNT_MAX) begin
                    inc_ovf[i] = 1'b1;
                end else begin
                    inc_val[i] = live_q[i] + CNT_ONE;
                end
`else
                inc_val[i] = live_q[i] + CNT_ONE;
                inc_ovf[i] = (live_q[i] == CNT_MAX);
`endif
            end
        end
    end

    // Next-state logic: window sequencing, counter updates, snapshots, CLEAR and config writes.
    always_comb begin
        logic capture;

        state_d     = state_q;
        remaining_d = remaining_q;
        window_d    = window_q;
        inhibit_d   = inhibit_q;
        ovf_d       = ovf_q | inc_ovf;
        live_d      = inc_val;
        shadow_d    = shadow_q;
        done_d      = 1'b0;
        capture     = snap_cmd;

        if (counting) begin
            if (remaining_q != WIN_ZERO) begin
                remaining_d = remaining_q - WIN_ONE;
            end
            if (stop_cmd) begin
                state_d = S_IDLE;
                capture = 1'b1;
            end else if (remaining_q == WIN_ONE) begin
                state_d = S_IDLE;
                capture = 1'b1;
                done_d  = 1'b1;
            end
        end else if (start_cmd) begin
            state_d     = S_COUNT;
            remaining_d = window_q;
        end

        if (capture) begin
            shadow_d = inc_val;
        end

        if (clear_cmd) begin
            live_d   = '0;
            shadow_d = '0;
            ovf_d    = '0;
        end

        if (cfg.cfg_we_i && (cfg.cfg_addr_i == ADDR_WINDOW)) begin
            window_d = cfg.cfg_wdata_i[WIN_W-1:0];
        end
        if (cfg.cfg_we_i && (cfg.cfg_addr_i == ADDR_INHIBIT)) begin
            inhibit_d = cfg.cfg_wdata_i[N_COMPS-1:0];
        end
    end

    // State register; asynchronous reset aborts any window in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            window_q    <= '0;
            inhibit_q   <= '0;
            ovf_q       <= '0;
            live_q      <= '0;
            shadow_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            window_q    <= window_d;
            inhibit_q   <= inhibit_d;
            ovf_q       <= ovf_d;
            live_q      <= live_d;
            shadow_q    <= shadow_d;
            done_q      <= done_d;
        end
    end

    // Read mux over current register state (read-before-write).
    always_comb begin
        cfg.cfg_rdata_o = '0;
        case (cfg.cfg_addr_i)
            ADDR_WINDOW: begin
                cfg.cfg_rdata_o = 32'(window_q);
            end
            ADDR_INHIBIT: begin
                cfg.cfg_rdata_o[N_COMPS-1:0] = inhibit_q;
            end
            ADDR_STATUS: begin
                cfg.cfg_rdata_o[1:0]          = state_q;
                cfg.cfg_rdata_o[8 +: N_COMPS] = ovf_q;
            end
            default: begin
                for (int i = 0; i < N_COMPS; i++) begin
                    if (cfg.cfg_addr_i == 4'(8 + i)) begin
                        cfg.cfg_rdata_o = 32'(shadow_q[i]);
                    end
                end
            end
        endcase
    end

    assign busy_o        = (state_q == S_COUNT);
    assign window_done_o = done_q;

endmodule

// File: tb/tb_topdown_counter_ctrl.sv
// Testbench for topdown_counter_ctrl: directed scenarios plus random traffic,
// checked by a scoreboard against a window/total-count reference model.
module tb_topdown_counter_ctrl;

    localparam int          N_COMPS = 6;
    localparam int          CNT_W   = 8;
    localparam int          WIN_W   = 32;
    localparam longint      CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N_COMPS-1:0] comp_incr = '0;
    logic               busy;
    logic               window_done;

    topdown_counter_ctrl_if bus_if ();

    topdown_counter_ctrl #(
        .N_COMPS (N_COMPS),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg           (bus_if.slave),
        .comp_incr_i   (comp_incr),
        .busy_o        (busy),
        .window_done_o (window_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        done;
        logic [31:0] rdata;
        logic [3:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: a window is an interval of cycle numbers, each counter is
    // the total number of accepted pulses since the last CLEAR.
    longint      cyc;
    bit          m_active;
    longint      m_end;
    longint      m_done_at;
    longint      m_total[N_COMPS];
    longint      m_shadow[N_COMPS];
    longint      m_window;
    bit [N_COMPS-1:0] m_inhibit;

    function automatic longint cntVal(input int i);
`ifdef TOPDOWN_CNT_SATURATE_EN
        return (m_total[i] > CNT_MAX) ? CNT_MAX : m_total[i];
`else
        return m_total[i] % (CNT_MAX + 1);
`endif
    endfunction

    function automatic logic [31:0] modelRead(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 4'd1) begin
            r = 32'(m_window);
        end else if (a == 4'd2) begin
            r = 32'(m_inhibit);
        end else if (a == 4'd3) begin
            r[0] = m_active;
            for (int i = 0; i < N_COMPS; i++) r[8+i] = (m_total[i] > CNT_MAX);
        end else if (a >= 4'd8 && int'(a) - 8 < N_COMPS) begin
            r = 32'(m_shadow[int'(a) - 8]);
        end
        return r;
    endfunction

    task automatic modelReset();
        m_active  = 1'b0;
        m_end     = 0;
        m_done_at = -1;
        m_window  = 0;
        m_inhibit = '0;
        for (int i = 0; i < N_COMPS; i++) begin
            m_total[i]  = 0;
            m_shadow[i] = 0;
        end
    endtask

    task automatic modelStep(input logic we, input logic [3:0] addr,
                             input logic [31:0] wdata, input logic [N_COMPS-1:0] incr);
        bit ctrl, start, stop, clr, capture;
        ctrl    = we && (addr == 4'd0);
        stop    = ctrl && wdata[1];
        start   = ctrl && wdata[0] && !wdata[1];
        clr     = ctrl && wdata[2];
        capture = ctrl && wdata[3];
        if (m_active) begin
            for (int i = 0; i < N_COMPS; i++)
                if (incr[i] && !m_inhibit[i]) m_total[i]++;
            if (stop) begin
                m_active = 1'b0;
                capture  = 1'b1;
            end else if (m_end != 0 && cyc == m_end) begin
                m_active  = 1'b0;
                capture   = 1'b1;
                m_done_at = cyc + 1;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_end    = (m_window == 0) ? 0 : cyc + m_window;
        end
        if (capture)
            for (int i = 0; i < N_COMPS; i++) m_shadow[i] = cntVal(i);
        if (clr)
            for (int i = 0; i < N_COMPS; i++) begin
                m_total[i]  = 0;
                m_shadow[i] = 0;
            end
        if (we && addr == 4'd1) m_window = longint'(wdata);
        if (we && addr == 4'd2) m_inhibit = wdata[N_COMPS-1:0];
    endtask

    // Drive one cycle of inputs, queue the expected outputs for it, advance the model.
    task automatic applyStimulus(input logic rst_v, input logic we, input logic [3:0] addr,
                                 input logic [31:0] wdata, input logic [N_COMPS-1:0] incr);
        exp_t e;
        rst_n              = rst_v;
        bus_if.cfg_we_i    = we;
        bus_if.cfg_addr_i  = addr;
        bus_if.cfg_wdata_i = wdata;
        comp_incr          = incr;
        if (!rst_v) modelReset();
        e.busy  = m_active;
        e.done  = (cyc == m_done_at);
        e.rdata = modelRead(addr);
        e.addr  = addr;
        exp_q.push_back(e);
        if (rst_v) modelStep(we, addr, wdata, incr);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [N_COMPS-1:0] incr);
        applyStimulus(1'b1, 1'b1, addr, data, incr);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [N_COMPS-1:0] incr);
        applyStimulus(1'b1, 1'b0, addr, 32'h0, incr);
    endtask

    task automatic readAll();
        rd(4'd3, '0);
        for (int i = 0; i < N_COMPS; i++) rd(4'(8 + i), '0);
    endtask

    task automatic checkOutput(input exp_t e);
        total++;
        if (busy !== e.busy) begin
            bad++;
            $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e.busy);
        end
        total++;
        if (window_done !== e.done) begin
            bad++;
            $display("[TB] FAIL window_done cyc=%0d got=%b exp=%b", cyc, window_done, e.done);
        end
        total++;
        if (bus_if.cfg_rdata_o !== e.rdata) begin
            bad++;
            $display("[TB] FAIL rdata addr=%0d got=%h exp=%h", e.addr, bus_if.cfg_rdata_o, e.rdata);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        logic we;
        logic [3:0] addr;
        logic [31:0] wdata;
        cyc = 0;
        modelReset();
        bus_if.cfg_we_i    = 1'b0;
        bus_if.cfg_addr_i  = '0;
        bus_if.cfg_wdata_i = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'(3 + i), 32'h0, '0);
        readAll();

        // Full window on component 0
        $display("[TB] window of 10 on comp 0");
        wr(4'd1, 32'd10, '0);
        wr(4'd0, 32'h1, 6'b000001);
        for (int i = 0; i < 12; i++) rd(4'd8, 6'b000001);
        readAll();

        // Inhibited component
        $display("[TB] inhibit comp 1");
        wr(4'd2, 32'h2, '0);
        wr(4'd1, 32'd5, '0);
        wr(4'd0, 32'h1, 6'b000011);
        for (int i = 0; i < 7; i++) rd(4'd2, 6'b000011);
        readAll();

        // Counter wrap with overflow flag
        $display("[TB] overflow on comp 3");
        wr(4'd2, 32'h0, '0);
        wr(4'd0, 32'h4, '0);
        wr(4'd1, 32'd300, '0);
        wr(4'd0, 32'h1, 6'b001000);
        for (int i = 0; i < 302; i++) rd(4'(i % 4), 6'b001000);
        readAll();

        // Unbounded window ended by STOP
        $display("[TB] unbounded window on comp 5");
        wr(4'd1, 32'd0, '0);
        wr(4'd0, 32'h1, '0);
        for (int i = 0; i < 8; i++) rd(4'd3, (i % 2 == 0) ? 6'b100000 : 6'b000000);
        for (int i = 0; i < 5; i++) rd(4'd3, '0);
        wr(4'd0, 32'h2, '0);
        for (int i = 0; i < 3; i++) rd(4'd13, 6'b100000);
        readAll();

        // CLEAR+START together drops the write-cycle pulse and clears ovf
        $display("[TB] clear+start on comp 2");
        wr(4'd1, 32'd8, '0);
        wr(4'd0, 32'h5, 6'b000100);
        for (int i = 0; i < 10; i++) rd(4'd10, 6'b000100);
        readAll();

        // Reset in the middle of an unbounded window
        $display("[TB] reset mid-window");
        wr(4'd1, 32'd0, '0);
        wr(4'd0, 32'h1, '0);
        for (int i = 0; i < 20; i++) rd(4'd3, 6'($urandom));
        wr(4'd0, 32'h8, 6'($urandom));
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 4'(8 + i), 32'h0, '1);
        readAll();

        // Random traffic
        $display("[TB] random traffic");
        for (int n = 0; n < 2500; n++) begin
            r    = int'($urandom_range(0, 9));
            we   = (r < 2);
            addr = 4'($urandom_range(0, 15));
            if (we && r == 0) addr = 4'($urandom_range(0, 2));
            case (addr)
                4'd0:    wdata = 32'($urandom_range(0, 15));
                4'd1:    wdata = 32'($urandom_range(0, 30));
                default: wdata = $urandom;
            endcase
            applyStimulus(1'b1, we, addr, wdata, 6'($urandom));
        end
        wr(4'd0, 32'h2, '0);
        readAll();
        rd(4'd0, '0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
